// File: rtl/mem_latency_bridge.sv
// mem_latency_bridge: a single-outstanding request/response bridge in front of
// a byte-addressable memory with a fixed access latency. It also provides a
// sticky halt flag, raised by a magic-byte write, and a free-running cycle counter.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : bridge can accept a request (IDLE, not halted, out of reset)
//   req_we     : byte write enables, all-zero = read
//   req_addr   : byte address
//   req_wdata  : write data, lane i = bits 8i+7:8i
//   rsp_valid  : one-cycle response strobe
//   rsp_rdata  : read data while rsp_valid, else 0
//   rsp_err    : misaligned request flag while rsp_valid, else 0
//   halt       : sticky end-of-program flag
//   cyc_cnt    : cycles since reset release until halt (saturating)
module mem_latency_bridge #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       LATENCY   = 2,
    parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(16'hfffc),
    parameter logic [7:0]        HALT_VAL  = 8'hff
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_W/8-1:0]   req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  halt,
    output logic [31:0]           cyc_cnt
);

    localparam int unsigned       BYTES     = DATA_W / 8;
    localparam int unsigned       AL        = $clog2(BYTES);
    localparam int unsigned       WIDX      = ADDR_W - AL;
    localparam int unsigned       DEPTH     = 1 << WIDX;
    localparam int unsigned       CNT_W     = 3;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] HALT_WORD = HALT_ADDR & ~LANE_MASK;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
    logic [BYTES-1:0]  we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [BYTES-1:0]  cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_misaligned;
    logic              commit;
    logic              halt_hit;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              halt_d;
    logic [31:0]       cyc_cnt_d;

    // Ready is forced low during reset and rises as soon as reset is released.
    assign req_ready = rst && (state == S_IDLE) && !halt;
    assign accept    = req_valid && req_ready;

    // State register and request latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            we_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Next-state: WAIT lasts LATENCY-1 cycles, skipped entirely for LATENCY=1.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    wait_cnt_d = '0;
                    state_d    = (LATENCY <= 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == CNT_W'(LATENCY - 2)) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response/halt/counter next values; on IDLE->RESP the request is still on the bus.
    always_comb begin
        cur_we         = (state == S_IDLE) ? req_we : we_q;
        cur_addr       = (state == S_IDLE) ? req_addr : addr_q;
        cur_misaligned = (cur_addr & LANE_MASK) != '0;

        rsp_valid_d = (state_d == S_RESP);
        rsp_err_d   = rsp_valid_d && cur_misaligned;
        rsp_rdata_d = '0;
        if (rsp_valid_d && !cur_misaligned && (cur_we == '0)) begin
            rsp_rdata_d = mem[WIDX'(cur_addr >> AL)];
        end

        commit = (state == S_RESP) && (we_q != '0) && ((addr_q & LANE_MASK) == '0);

        // Any enabled lane of the word holding HALT_ADDR carrying HALT_VAL raises halt.
        halt_hit = 1'b0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (commit && (addr_q == HALT_WORD) && we_q[i] &&
                (wdata_q[8*i +: 8] == HALT_VAL)) begin
                halt_hit = 1'b1;
            end
        end
        halt_d = halt || halt_hit;

        cyc_cnt_d = (halt || (cyc_cnt == '1)) ? cyc_cnt : cyc_cnt + 32'd1;
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            halt      <= 1'b0;
            cyc_cnt   <= '0;
        end else begin
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            halt      <= halt_d;
            cyc_cnt   <= cyc_cnt_d;
        end
    end

    // Memory array, outside control reset; writes commit on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                if (we_q[i]) begin
                    mem[WIDX'(addr_q >> AL)][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
